assoc_cache_ctrl: RTL and testbench
===================================

ASSOC_CACHE_CTRL -- requirements
Module: assoc_cache_ctrl

Interface
REQ-001 Parameter WAYS, 2, number of ways (power of 2, 2..8).
REQ-002 Parameter TAG_W, 5, tag width.
REQ-003 Parameter INDEX_W, 8, set index width.
REQ-004 Parameter WORDS, 4, 16-bit words per line (power of 2); OFF_W = log2(WORDS)+1 byte-offset bits.
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst  in  1  reset, asynchronous, active-low.
REQ-007 Ports req_rd/req_wr  in  1  core read/write request; both high is treated as write.
REQ-008 Port req_addr  in  TAG_W+INDEX_W+OFF_W  core byte address {tag,index,offset}.
REQ-009 Ports way_valid/way_dirty/way_hit  in  WAYS  per-way valid, dirty and tag-match at the presented index.
REQ-010 Port way_tag  in  WAYS*TAG_W  stored tag per way, way 0 in LSBs.
REQ-011 Ports mem_req/mem_we  out  1  memory request and write-enable, held until mem_ack.
REQ-012 Port mem_addr  out  address width  word-aligned memory address.
REQ-013 Port mem_ack  in  1  memory beat accepted/read data valid this cycle.
REQ-014 Ports way_sel  out  WAYS  one-hot way under access; cache_index/cache_off  out  INDEX_W/OFF_W  array address.
REQ-015 Ports data_wr, tag_wr, valid_in, dirty_in, data_src (0 core, 1 memory)  out  1  array write controls.
REQ-016 Ports stall, done, cache_hit  out  1  core status.

Function
REQ-017 States: IDLE, WB, FILL, REPLAY; encoding in shared package.
REQ-018 IDLE: stall=0; hit = (req_rd|req_wr) & |(way_hit & way_valid); on hit done=1, cache_hit=1, way_sel=hitting way, same cycle.
REQ-019 Write hit: data_wr=1, dirty_in=1, valid_in=1, data_src=0, cache_off=req offset.
REQ-020 Miss: latch req_addr, rd/wr and victim way; stall=1 from next cycle; next state WB if victim valid & dirty, else FILL.
REQ-021 Victim: lowest-numbered invalid way, else per-set round-robin pointer[index]; pointer advances (mod WAYS) when a fill completes.
REQ-022 WB: beats 0..WORDS-1; mem_addr={way_tag[victim], index, beat, 0}; mem_we=1; cache_off follows beat; beat advances only on mem_ack; after last ack -> FILL.
REQ-023 FILL: mem_we=0, mem_addr={latched tag, index, beat, 0}; on each mem_ack data_wr=1, data_src=1, cache_off=beat; last beat also tag_wr=1, valid_in=1, dirty_in=0; then REPLAY.
REQ-024 REPLAY: one cycle, done=1, stall=1, cache_hit=0; read returns latched-offset word; write performs the REQ-019 write; -> IDLE.
REQ-025 Request inputs ignored outside IDLE; mem_ack in IDLE or REPLAY ignored.
REQ-026 Beat counter width log2(WORDS), wraps to 0 on WB->FILL transition.
REQ-027 No combinational path mem_ack -> mem_req.

Reset
REQ-028 rst low: state IDLE, beat 0, all round-robin pointers 0, latched request cleared, all outputs 0 except stall=0; asynchronous assertion, synchronous-safe deassertion.
REQ-029 Reset mid-WB/FILL abandons the transaction; mem_req drops immediately.

Structure
REQ-030 Package holds state enum, default parameter values and address-field width functions.
REQ-031 One sub-module, cache_victim_sel: per-set round-robin pointers plus invalid-way priority encoder.

Verification
REQ-032 WAYS=2, read hit way 1 at index 0x12 -> done=1, way_sel=2'b10, stall=0, same cycle.
REQ-033 Write miss, victim dirty tag 0x1A, index 0x05, mem_ack 2 cycles per beat -> 4 write beats at 0x1A05 base offsets 0,2,4,6, 4 fill beats, REPLAY write dirty_in=1.
REQ-034 Two misses same set, all ways valid clean -> victims way 0 then way 1 (WAYS=2), pointer wraps to 0 on third.
REQ-035 req_rd and req_wr toggled during FILL -> no effect; mem_ack asserted in IDLE -> no mem_req.
REQ-036 rst low during WB beat 2 -> mem_req=0 same cycle, state IDLE, next request serviced normally.
REQ-037 WAYS=4, WORDS=8: read miss with ways 0,2 invalid -> victim way 0, 8 fill beats, done in REPLAY.

Source files
------------

// File: rtl/assoc_cache_ctrl_pkg.sv
// Shared definitions for the set-associative cache controller.
// Contents: controller state encoding, default parameter values, and helpers
// that derive field widths (beat counter, byte offset, way index, address).
package assoc_cache_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WB     = 2'd1,
      ST_FILL   = 2'd2,
      ST_REPLAY = 2'd3
   } cache_state_e;

   localparam int DEF_WAYS    = 2;
   localparam int DEF_TAG_W   = 5;
   localparam int DEF_INDEX_W = 8;
   localparam int DEF_WORDS   = 4;

   // Word-within-line counter width.
   function automatic int beat_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   // Byte offset: word select plus one byte bit for 16-bit words.
   function automatic int off_width(input int words);
      return beat_width(words) + 1;
   endfunction

   function automatic int way_width(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   function automatic int addr_width(input int tag_w, input int index_w, input int words);
      return tag_w + index_w + off_width(words);
   endfunction

endpackage

// File: rtl/assoc_cache_ctrl_victim_sel.sv
// cache_victim_sel: picks the way to replace on a miss.
// The lowest-numbered invalid way wins; when every way is valid the per-set
// round-robin pointer for the presented index is used. The pointer of set
// adv_index steps by one (mod WAYS) whenever adv pulses.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (pointers -> 0)
//   way_valid         per-way valid bits at the presented index
//   index             presented set index (pointer lookup)
//   adv, adv_index    advance request and the set it applies to
//   victim_idx        binary index of the chosen way
module cache_victim_sel
   import assoc_cache_ctrl_pkg::*;
#(
   parameter int WAYS    = DEF_WAYS,
   parameter int INDEX_W = DEF_INDEX_W,
   localparam int WAY_W  = way_width(WAYS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WAYS-1:0]    way_valid,
   input  logic [INDEX_W-1:0] index,
   input  logic               adv,
   input  logic [INDEX_W-1:0] adv_index,
   output logic [WAY_W-1:0]   victim_idx
);

   localparam int SETS = 1 << INDEX_W;

   logic [WAY_W-1:0] ptr_q [SETS];
   logic [WAY_W-1:0] ptr_d [SETS];
   logic             inv_found;
   logic [WAY_W-1:0] inv_idx;

   // Descending scan so the lowest invalid way is the last one written.
   always_comb begin
      inv_found = 1'b0;
      inv_idx   = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!way_valid[i]) begin
            inv_found = 1'b1;
            inv_idx   = WAY_W'(i);
         end
      end
   end

   assign victim_idx = inv_found ? inv_idx : ptr_q[index];

   // WAYS is a power of two, so the natural WAY_W-bit wrap is the modulo.
   always_comb begin
      ptr_d = ptr_q;
      if (adv) begin
         ptr_d[adv_index] = ptr_q[adv_index] + WAY_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SETS; i++) begin
            ptr_q[i] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: miss-handling controller for a write-back set-associative
// cache. Hits complete in the request cycle; a miss writes back a dirty victim
// line, fills the line from memory one word per beat, then replays the access.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   req_rd, req_wr, req_addr         core request (both high = write), {tag,index,offset}
//   way_valid/dirty/hit, way_tag     tag-array status at the presented index
//   mem_req, mem_we, mem_addr        memory beat request (held until mem_ack)
//   mem_ack                          beat accepted / read data valid
//   way_sel, cache_index, cache_off  data-array access address
//   data_wr, tag_wr, valid_in,
//   dirty_in, data_src               data/tag array write controls (data_src 1 = memory)
//   stall, done, cache_hit           core status
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | accept requests; hits serviced same cycle, misses latched
// ST_WB     | write dirty victim line to memory, one word per mem_ack
// ST_FILL   | read the missing line from memory into the victim way
// ST_REPLAY | one cycle: complete the latched read or write against the new line
module assoc_cache_ctrl
   import assoc_cache_ctrl_pkg::*;
#(
   parameter int WAYS    = DEF_WAYS,
   parameter int TAG_W   = DEF_TAG_W,
   parameter int INDEX_W = DEF_INDEX_W,
   parameter int WORDS   = DEF_WORDS,
   localparam int OFF_W  = off_width(WORDS),
   localparam int AW     = addr_width(TAG_W, INDEX_W, WORDS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_rd,
   input  logic                  req_wr,
   input  logic [AW-1:0]         req_addr,
   input  logic [WAYS-1:0]       way_valid,
   input  logic [WAYS-1:0]       way_dirty,
   input  logic [WAYS-1:0]       way_hit,
   input  logic [WAYS*TAG_W-1:0] way_tag,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [AW-1:0]         mem_addr,
   input  logic                  mem_ack,
   output logic [WAYS-1:0]       way_sel,
   output logic [INDEX_W-1:0]    cache_index,
   output logic [OFF_W-1:0]      cache_off,
   output logic                  data_wr,
   output logic                  tag_wr,
   output logic                  valid_in,
   output logic                  dirty_in,
   output logic                  data_src,
   output logic                  stall,
   output logic                  done,
   output logic                  cache_hit
);

   localparam int WAY_W  = way_width(WAYS);
   localparam int BEAT_W = beat_width(WORDS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

   cache_state_e      state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [AW-1:0]     lat_addr_q, lat_addr_d;
   logic              lat_wr_q, lat_wr_d;
   logic [WAY_W-1:0]  victim_q, victim_d;

   logic               req_any;
   logic [WAYS-1:0]    hit_vec, hit_oh, victim_oh;
   logic [WAY_W-1:0]   new_victim;
   logic               rr_adv;
   logic [INDEX_W-1:0] req_index, lat_index;
   logic [OFF_W-1:0]   req_off, lat_off;
   logic [TAG_W-1:0]   lat_tag, victim_tag;

   assign req_any    = req_rd | req_wr;
   assign hit_vec    = way_hit & way_valid;
   // Isolate the lowest set bit so a multi-way match still selects one way.
   assign hit_oh     = hit_vec & (~hit_vec + WAYS'(1));
   assign req_index  = req_addr[OFF_W +: INDEX_W];
   assign req_off    = req_addr[OFF_W-1:0];
   assign lat_tag    = lat_addr_q[AW-1 -: TAG_W];
   assign lat_index  = lat_addr_q[OFF_W +: INDEX_W];
   assign lat_off    = lat_addr_q[OFF_W-1:0];
   assign victim_tag = way_tag[int'(victim_q)*TAG_W +: TAG_W];

   always_comb begin
      victim_oh           = '0;
      victim_oh[victim_q] = 1'b1;
   end

   cache_victim_sel #(
      .WAYS    (WAYS),
      .INDEX_W (INDEX_W)
   ) u_victim_sel (
      .clk        (clk),
      .rst        (rst),
      .way_valid  (way_valid),
      .index      (req_index),
      .adv        (rr_adv),
      .adv_index  (lat_index),
      .victim_idx (new_victim)
   );

   // mem_req/mem_we are decoded from state only; mem_ack merely steers the
   // next state, so there is no combinational path from mem_ack to mem_req.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      lat_addr_d  = lat_addr_q;
      lat_wr_d    = lat_wr_q;
      victim_d    = victim_q;
      rr_adv      = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      way_sel     = '0;
      cache_index = '0;
      cache_off   = '0;
      data_wr     = 1'b0;
      tag_wr      = 1'b0;
      valid_in    = 1'b0;
      dirty_in    = 1'b0;
      data_src    = 1'b0;
      stall       = 1'b0;
      done        = 1'b0;
      cache_hit   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               cache_index = req_index;
               cache_off   = req_off;
               if (|hit_vec) begin
                  done      = 1'b1;
                  cache_hit = 1'b1;
                  way_sel   = hit_oh;
                  if (req_wr) begin
                     data_wr  = 1'b1;
                     valid_in = 1'b1;
                     dirty_in = 1'b1;
                  end
               end else begin
                  lat_addr_d = req_addr;
                  lat_wr_d   = req_wr;
                  victim_d   = new_victim;
                  beat_d     = '0;
                  if (way_valid[new_victim] && way_dirty[new_victim]) begin
                     state_d = ST_WB;
                  end else begin
                     state_d = ST_FILL;
                  end
               end
            end
         end

         ST_WB: begin
            stall       = 1'b1;
            mem_req     = 1'b1;
            mem_we      = 1'b1;
            mem_addr    = {victim_tag, lat_index, beat_q, 1'b0};
            way_sel     = victim_oh;
            cache_index = lat_index;
            cache_off   = {beat_q, 1'b0};
            if (mem_ack) begin
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_FILL;
               end
            end
         end

         ST_FILL: begin
            stall       = 1'b1;
            mem_req     = 1'b1;
            mem_addr    = {lat_tag, lat_index, beat_q, 1'b0};
            way_sel     = victim_oh;
            cache_index = lat_index;
            cache_off   = {beat_q, 1'b0};
            if (mem_ack) begin
               data_wr  = 1'b1;
               data_src = 1'b1;
               beat_d   = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  tag_wr   = 1'b1;
                  valid_in = 1'b1;
                  rr_adv   = 1'b1;
                  state_d  = ST_REPLAY;
               end
            end
         end

         ST_REPLAY: begin
            stall       = 1'b1;
            done        = 1'b1;
            way_sel     = victim_oh;
            cache_index = lat_index;
            cache_off   = lat_off;
            if (lat_wr_q) begin
               data_wr  = 1'b1;
               valid_in = 1'b1;
               dirty_in = 1'b1;
            end
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         lat_addr_q <= '0;
         lat_wr_q   <= 1'b0;
         victim_q   <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         lat_addr_q <= lat_addr_d;
         lat_wr_q   <= lat_wr_d;
         victim_q   <= victim_d;
      end
   end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
module tb_assoc_cache_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Default configuration: WAYS=2, TAG_W=5, INDEX_W=8, WORDS=4 (16-bit address).
   logic        req_rd, req_wr, mem_ack;
   logic [15:0] req_addr;
   logic [1:0]  way_valid, way_dirty, way_hit;
   logic [9:0]  way_tag;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [1:0]  way_sel;
   logic [7:0]  cache_index;
   logic [2:0]  cache_off;
   logic        data_wr, tag_wr, valid_in, dirty_in, data_src, stall, done, cache_hit;

   // Wide configuration: WAYS=4, WORDS=8 (17-bit address).
   logic        req_rd4, req_wr4, mem_ack4;
   logic [16:0] req_addr4;
   logic [3:0]  way_valid4, way_dirty4, way_hit4;
   logic [19:0] way_tag4;
   logic        mem_req4, mem_we4;
   logic [16:0] mem_addr4;
   logic [3:0]  way_sel4;
   logic [7:0]  cache_index4;
   logic [3:0]  cache_off4;
   logic        data_wr4, tag_wr4, valid_in4, dirty_in4, data_src4, stall4, done4, cache_hit4;

   assoc_cache_ctrl dut (
      .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
      .way_valid(way_valid), .way_dirty(way_dirty), .way_hit(way_hit), .way_tag(way_tag),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .way_sel(way_sel), .cache_index(cache_index), .cache_off(cache_off),
      .data_wr(data_wr), .tag_wr(tag_wr), .valid_in(valid_in), .dirty_in(dirty_in),
      .data_src(data_src), .stall(stall), .done(done), .cache_hit(cache_hit)
   );

   assoc_cache_ctrl #(.WAYS(4), .WORDS(8)) dut4 (
      .clk(clk), .rst(rst), .req_rd(req_rd4), .req_wr(req_wr4), .req_addr(req_addr4),
      .way_valid(way_valid4), .way_dirty(way_dirty4), .way_hit(way_hit4), .way_tag(way_tag4),
      .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_ack(mem_ack4),
      .way_sel(way_sel4), .cache_index(cache_index4), .cache_off(cache_off4),
      .data_wr(data_wr4), .tag_wr(tag_wr4), .valid_in(valid_in4), .dirty_in(dirty_in4),
      .data_src(data_src4), .stall(stall4), .done(done4), .cache_hit(cache_hit4)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int rr [256];   // model of the per-set replacement pointer

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [1:0]  vld;
      logic [1:0]  hit;
      logic        exp_done;
      logic        exp_hit;
      logic [1:0]  exp_sel;
      logic        exp_dwr;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mk(input int tag, input int idx, input int off);
      return 16'((tag << 11) | (idx << 3) | off);
   endfunction

   // One memory beat: hold off mem_ack for lat cycles, then accept. Request
   // inputs are scrambled meanwhile; the controller must ignore them.
   task automatic serve_beat(input logic we, input int exp_addr, input int lat,
                             input logic fill, input logic last, input int vsel);
      for (int c = 0; c <= lat; c++) begin
         chk("beat_mem_req", mem_req, 1);
         chk("beat_mem_we", mem_we, we);
         chk("beat_mem_addr", mem_addr, exp_addr);
         if (c == lat) begin
            mem_ack = 1'b1;
            #1;
            chk("beat_data_wr", data_wr, fill);
            chk("beat_tag_wr", tag_wr, fill & last);
            chk("beat_way_sel", way_sel, 1 << vsel);
            chk("beat_cache_off", cache_off, exp_addr & 6);
            if (fill) chk("fill_data_src", data_src, 1);
            if (fill && last) begin
               chk("fill_valid_in", valid_in, 1);
               chk("fill_dirty_in", dirty_in, 0);
            end
         end else begin
            #1;
            chk("wait_data_wr", data_wr, 0);
         end
         req_rd   = 1'($urandom);
         req_wr   = 1'($urandom);
         req_addr = 16'($urandom);
         @(negedge clk);
         mem_ack = 1'b0;
         #1;
      end
   endtask

   // Full access against the model: hit in the request cycle, or miss with
   // optional write-back, line fill and replay.
   task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [1:0] vld, input logic [1:0] dty, input logic [1:0] hit,
                         input logic [9:0] tags, input int lat);
      int idx, tag, v, tagv;
      logic [1:0] hv;
      @(negedge clk);
      req_rd = rd; req_wr = wr; req_addr = addr;
      way_valid = vld; way_dirty = dty; way_hit = hit; way_tag = tags;
      #1;
      idx = int'(addr) >> 3 & 255;
      tag = int'(addr) >> 11;
      hv  = hit & vld;
      if (hv != 2'b00) begin
         chk("hit_done", done, 1);
         chk("hit_flag", cache_hit, 1);
         chk("hit_stall", stall, 0);
         chk("hit_way_sel", way_sel, hv[0] ? 1 : 2);
         chk("hit_data_wr", data_wr, wr);
         chk("hit_index", cache_index, idx);
         if (wr) begin
            chk("hit_dirty_in", dirty_in, 1);
            chk("hit_off", cache_off, int'(addr) & 7);
         end
         req_rd = 1'b0; req_wr = 1'b0;
         return;
      end
      chk("miss_done", done, 0);
      chk("miss_stall", stall, 0);
      v = -1;
      for (int w = 0; w < 2; w++) if (!vld[w] && v < 0) v = w;
      if (v < 0) v = rr[idx];
      tagv = (int'(tags) >> (v * 5)) & 31;
      @(negedge clk);
      #1;
      chk("busy_stall", stall, 1);
      chk("busy_done", done, 0);
      if (vld[v] && dty[v]) begin
         for (int b = 0; b < 4; b++)
            serve_beat(1'b1, (tagv << 11) | (idx << 3) | (b << 1), lat, 1'b0, 1'b0, v);
      end
      for (int b = 0; b < 4; b++)
         serve_beat(1'b0, (tag << 11) | (idx << 3) | (b << 1), lat, 1'b1, b == 3, v);
      req_rd = 1'b0; req_wr = 1'b0;
      #1;
      chk("replay_done", done, 1);
      chk("replay_stall", stall, 1);
      chk("replay_hit", cache_hit, 0);
      chk("replay_way_sel", way_sel, 1 << v);
      chk("replay_data_wr", data_wr, wr);
      chk("replay_dirty_in", dirty_in, wr);
      chk("replay_data_src", data_src, 0);
      chk("replay_off", cache_off, int'(addr) & 7);
      chk("replay_index", cache_index, idx);
      chk("replay_mem_req", mem_req, 0);
      rr[idx] = (rr[idx] + 1) % 2;
      @(negedge clk);
      #1;
      chk("back_idle_stall", stall, 0);
      chk("back_idle_done", done, 0);
      chk("back_idle_mem_req", mem_req, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int v, tagv;
      rst = 1'b0;
      req_rd = 0; req_wr = 0; req_addr = 0; mem_ack = 0;
      way_valid = 0; way_dirty = 0; way_hit = 0; way_tag = 0;
      req_rd4 = 0; req_wr4 = 0; req_addr4 = 0; mem_ack4 = 0;
      way_valid4 = 0; way_dirty4 = 0; way_hit4 = 0; way_tag4 = 0;
      for (int i = 0; i < 256; i++) rr[i] = 0;

      vecs[0] = '{1'b1, 1'b0, mk(3, 'h12, 2), 2'b11, 2'b10, 1'b1, 1'b1, 2'b10, 1'b0};
      vecs[1] = '{1'b0, 1'b1, mk(7, 'h12, 5), 2'b11, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1};
      vecs[2] = '{1'b1, 1'b1, mk(1, 'h40, 6), 2'b10, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1};
      vecs[3] = '{1'b0, 1'b0, mk(0, 'h12, 0), 2'b11, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0};
      vecs[4] = '{1'b1, 1'b0, mk(2, 'h07, 1), 2'b01, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0};
      vecs[5] = '{1'b1, 1'b0, mk(4, 'h20, 3), 2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 1'b0};
      vecs[6] = '{1'b0, 1'b1, mk(9, 'h33, 7), 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0};

      repeat (3) @(negedge clk);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      chk("rst_way_sel", way_sel, 0);
      chk("rst_data_wr", data_wr, 0);
      chk("rst_tag_wr", tag_wr, 0);
      chk("rst_mem_req4", mem_req4, 0);
      @(negedge clk);
      rst = 1'b1;

      // Single-cycle IDLE behaviour; requests withdrawn before the clock edge.
      foreach (vecs[i]) begin
         @(negedge clk);
         req_rd = vecs[i].rd; req_wr = vecs[i].wr; req_addr = vecs[i].addr;
         way_valid = vecs[i].vld; way_hit = vecs[i].hit; way_dirty = 2'b00;
         #1;
         chk($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
         chk($sformatf("vec%0d_cache_hit", i), cache_hit, vecs[i].exp_hit);
         chk($sformatf("vec%0d_way_sel", i), way_sel, vecs[i].exp_sel);
         chk($sformatf("vec%0d_data_wr", i), data_wr, vecs[i].exp_dwr);
         chk($sformatf("vec%0d_stall", i), stall, 0);
         chk($sformatf("vec%0d_mem_req", i), mem_req, 0);
         if (vecs[i].exp_dwr) begin
            chk($sformatf("vec%0d_dirty_in", i), dirty_in, 1);
            chk($sformatf("vec%0d_data_src", i), data_src, 0);
            chk($sformatf("vec%0d_off", i), cache_off, vecs[i].addr[2:0]);
         end
         req_rd = 1'b0; req_wr = 1'b0;
      end

      // Write miss on dirty victim (tag 0x1A, index 0x05), ack 2 cycles per beat.
      do_req(1'b0, 1'b1, mk('h0B, 'h05, 4), 2'b11, 2'b01, 2'b00, {5'h02, 5'h1A}, 1);

      // Three clean misses in one full set: victims 0, 1, then 0 again.
      for (int k = 0; k < 3; k++)
         do_req(1'b1, 1'b0, mk(k + 3, 'h33, 0), 2'b11, 2'b00, 2'b00, 10'h155, 0);

      // mem_ack while idle must not start anything.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         mem_ack = 1'b1;
         #1;
         chk("idle_ack_mem_req", mem_req, 0);
         chk("idle_ack_stall", stall, 0);
      end
      @(negedge clk);
      mem_ack = 1'b0;

      // Reset asserted during write-back beat 2.
      @(negedge clk);
      req_wr = 1'b1; req_addr = mk(2, 'h44, 0);
      way_valid = 2'b11; way_dirty = 2'b11; way_hit = 2'b00; way_tag = {5'h11, 5'h0C};
      v = rr['h44];
      tagv = v ? 'h11 : 'h0C;
      @(negedge clk);
      req_wr = 1'b0;
      #1;
      serve_beat(1'b1, (tagv << 11) | ('h44 << 3) | (0 << 1), 0, 1'b0, 1'b0, v);
      serve_beat(1'b1, (tagv << 11) | ('h44 << 3) | (1 << 1), 0, 1'b0, 1'b0, v);
      req_rd = 1'b0; req_wr = 1'b0;
      chk("pre_rst_mem_req", mem_req, 1);
      chk("pre_rst_mem_addr", mem_addr, (tagv << 11) | ('h44 << 3) | (2 << 1));
      rst = 1'b0;
      #1;
      chk("mid_rst_mem_req", mem_req, 0);
      chk("mid_rst_mem_we", mem_we, 0);
      chk("mid_rst_stall", stall, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 256; i++) rr[i] = 0;
      #1;
      chk("post_rst_mem_req", mem_req, 0);
      do_req(1'b0, 1'b1, mk(5, 'h44, 2), 2'b11, 2'b11, 2'b00, {5'h11, 5'h0C}, 0);

      // WAYS=4, WORDS=8: read miss with ways 0 and 2 invalid.
      @(negedge clk);
      req_rd4 = 1'b1; req_addr4 = 17'((9 << 12) | ('h21 << 4) | 6);
      way_valid4 = 4'b1010; way_dirty4 = 4'b1111; way_hit4 = 4'b0000; way_tag4 = 20'hABCDE;
      #1;
      chk("w4_miss_done", done4, 0);
      @(negedge clk);
      req_rd4 = 1'b0;
      #1;
      chk("w4_stall", stall4, 1);
      for (int b = 0; b < 8; b++) begin
         chk("w4_mem_req", mem_req4, 1);
         chk("w4_mem_we", mem_we4, 0);
         chk("w4_mem_addr", mem_addr4, (9 << 12) | ('h21 << 4) | (b << 1));
         chk("w4_way_sel", way_sel4, 4'b0001);
         mem_ack4 = 1'b1;
         #1;
         chk("w4_data_wr", data_wr4, 1);
         chk("w4_tag_wr", tag_wr4, b == 7);
         @(negedge clk);
         mem_ack4 = 1'b0;
         #1;
      end
      chk("w4_replay_done", done4, 1);
      chk("w4_replay_stall", stall4, 1);
      chk("w4_replay_hit", cache_hit4, 0);
      chk("w4_replay_data_wr", data_wr4, 0);
      chk("w4_replay_off", cache_off4, 6);
      @(negedge clk);
      #1;
      chk("w4_idle_stall", stall4, 0);

      // Random accesses against the model.
      for (int t = 0; t < 40; t++) begin
         logic rd, wr;
         logic [1:0] vld, dty, hit;
         wr  = 1'($urandom);
         rd  = wr ? 1'($urandom) : 1'b1;
         vld = 2'($urandom); dty = 2'($urandom); hit = 2'($urandom);
         do_req(rd, wr, mk($urandom_range(31), 'h80 + $urandom_range(3), $urandom_range(7)),
                vld, dty, hit, 10'($urandom), $urandom_range(2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
